palette_lut_dbuf: RTL and testbench



---
 rtl/palette_lut_dbuf.sv | 210 +++++++++++++++++++++
 tb/tb_palette_lut_dbuf.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lut_dbuf.sv
// -----------------------------------------------------------------------------
// palette_lut_dbuf
//
// Double-buffered programmable colour palette. Game logic writes colours into
// the shadow bank through a ready/valid write port. A commit arms a bank swap,
// and the swap itself happens on the next frame_start so the display never
// sees a half-updated table. After the swap the new active bank is copied
// entry by entry into the new shadow. Further edits then start from what is
// currently on screen.
//
// The read path is a fixed two-stage pipeline. It never stalls and is
// independent of the swap state machine:
//   stage 1 : register the lookup request (valid, index, blank, fade)
//   stage 2 : read the active bank, apply fade and blanking, register colour
//
// Parameters
//   INDEX_W  palette index width (2**INDEX_W entries per bank)
//   COLOR_W  bits per colour channel (entry = {red, green, blue})
//
// Ports
//   clk          pixel clock
//   reset_n      asynchronous active-low reset
//   frame_start  one-cycle pulse at the start of vertical blank
//   wr_valid     palette write request
//   wr_ready     write accepted when wr_valid && wr_ready (IDLE only)
//   wr_index     entry to write in the shadow bank
//   wr_rgb       colour {r,g,b} to write
//   commit       one-cycle pulse requesting a shadow-to-active swap
//   busy         high while a swap is pending or the copy-back is running
//   active_bank  bank currently read by the display
//   rd_valid     lookup request
//   index        lookup index
//   blank        force black for this pixel
//   fade         brightness, all-ones = full intensity
//   out_valid    colour valid (two cycles after the request)
//   red/green/blue  looked-up, faded, blanked colour
// -----------------------------------------------------------------------------
module palette_lut_dbuf #(
    parameter int INDEX_W = 4,
    parameter int COLOR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [INDEX_W-1:0]     wr_index,
    input  logic [3*COLOR_W-1:0]   wr_rgb,
    input  logic                   commit,
    output logic                   busy,
    output logic                   active_bank,
    input  logic                   rd_valid,
    input  logic [INDEX_W-1:0]     index,
    input  logic                   blank,
    input  logic [COLOR_W-1:0]     fade,
    output logic                   out_valid,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam int RGB_W = 3 * COLOR_W;
    localparam int PROD_W = 2 * COLOR_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_COPY    = 2'd2;

    // Scales one channel by (fade+1)/2**COLOR_W. The +1 makes all-ones an
    // exact identity and zero a full black, with no separate special cases.
    function automatic logic [COLOR_W-1:0] fade_scale(
        input logic [COLOR_W-1:0] c,
        input logic [COLOR_W-1:0] f
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * (PROD_W'(f) + PROD_W'(1));
        return prod[PROD_W-1:COLOR_W];
    endfunction

    logic [1:0]          state;
    logic [INDEX_W-1:0]  cnt;
    logic                shadow_bank;
    logic                wr_fire;
    logic                copy_en;

    logic [RGB_W-1:0]    mem [2][DEPTH];

    assign shadow_bank = ~active_bank;
    assign wr_ready    = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign wr_fire     = wr_valid && wr_ready;
    assign copy_en     = (state == ST_COPY);

    // Swap controller. A commit in IDLE only arms the swap. A frame_start
    // arriving in that same cycle is deliberately not acted on, because the
    // state is still IDLE when it is sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            active_bank <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (frame_start) begin
                        active_bank <= ~active_bank;
                        cnt         <= '0;
                        state       <= ST_COPY;
                    end
                end
                ST_COPY: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Palette storage. Writes are only accepted in IDLE and the copy-back only
    // runs in COPY, so the two shadow-bank write sources never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem[b][e] <= '0;
                end
            end
        end else begin
            if (wr_fire) begin
                mem[shadow_bank][wr_index] <= wr_rgb;
            end
            if (copy_en) begin
                mem[shadow_bank][cnt] <= mem[active_bank][cnt];
            end
        end
    end

    // ---- stage 1: request registers ----
    logic                vld_p1;
    logic [INDEX_W-1:0]  idx_p1;
    logic                blank_p1;
    logic [COLOR_W-1:0]  fade_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_valid;
        end
    end

    // Request data is only captured for real lookups, so stage 2 never
    // consumes an uninitialised index.
    always_ff @(posedge clk) begin
        if (rd_valid) begin
            idx_p1   <= index;
            blank_p1 <= blank;
            fade_p1  <= fade;
        end
    end

    // ---- stage 2: bank read, fade, blank, output registers ----
    // The bank is selected with the live active_bank. A lookup in stage 2 during
    // the swap cycle still sees the old bank. From the following cycle on it
    // sees the new one.
    logic [RGB_W-1:0]    rd_rgb_p1;
    logic [COLOR_W-1:0]  r_p1;
    logic [COLOR_W-1:0]  g_p1;
    logic [COLOR_W-1:0]  b_p1;

    always_comb begin
        rd_rgb_p1 = mem[active_bank][idx_p1];
        r_p1      = '0;
        g_p1      = '0;
        b_p1      = '0;
        if (!blank_p1) begin
            r_p1 = fade_scale(rd_rgb_p1[RGB_W-1 -: COLOR_W], fade_p1);
            g_p1 = fade_scale(rd_rgb_p1[2*COLOR_W-1 -: COLOR_W], fade_p1);
            b_p1 = fade_scale(rd_rgb_p1[COLOR_W-1:0], fade_p1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                red   <= r_p1;
                green <= g_p1;
                blue  <= b_p1;
            end
        end
    end

endmodule

// File: tb/tb_palette_lut_dbuf.sv
module tb_palette_lut_dbuf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        commit;
    logic        busy;
    logic        active_bank;
    logic        rd_valid;
    logic [3:0]  index;
    logic        blank;
    logic [3:0]  fade;
    logic        out_valid;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        got_vld;
    logic [11:0] got_rgb;

    palette_lut_dbuf #(.INDEX_W(4), .COLOR_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index),
        .wr_rgb(wr_rgb), .commit(commit), .busy(busy),
        .active_bank(active_bank), .rd_valid(rd_valid), .index(index),
        .blank(blank), .fade(fade), .out_valid(out_valid),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [3:0] idx, input logic bl, input logic [3:0] fd);
        rd_valid = 1'b1; index = idx; blank = bl; fade = fd;
        tick;
        rd_valid = 1'b0;
        tick;
        got_vld = out_valid;
        got_rgb = {red, green, blue};
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [11:0] rgb);
        wr_valid = 1'b1; wr_index = idx; wr_rgb = rgb;
        tick;
        wr_valid = 1'b0;
    endtask

    task automatic do_swap;
        int n;
        commit = 1'b1;
        tick;
        commit = 1'b0;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n = 0;
        while (busy && n < 64) begin tick; n++; end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL swap_done: busy=%0b want 0", busy); end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        frame_start = 0; wr_valid = 0; wr_index = 0; wr_rgb = 0; commit = 0;
        rd_valid = 0; index = 0; blank = 0; fade = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %0b want 1", wr_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL rst_bank: got %0b want 0", active_bank); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_checks++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL rst_rgb: got %03h want 000", {red, green, blue}); end
        reset_n = 1'b1;
        tick;
        lookup(4'd5, 1'b0, 4'hF);
        n_checks++; if (got_vld !== 1'b1) begin n_fail++; $display("FAIL rst_lookup_vld: got %0b want 1", got_vld); end
        n_checks++; if (got_rgb !== 12'h000) begin n_fail++; $display("FAIL rst_lookup_rgb: got %03h want 000", got_rgb); end
    endtask

    task automatic test_write_commit;
        int n;
        do_write(4'd3, 12'hA97);
        commit = 1'b1;
        tick;
        commit = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wc_busy_pending: got %0b want 1", busy); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL wc_ready_pending: got %0b want 0", wr_ready); end
        lookup(4'd3, 1'b0, 4'hF);
        n_checks++; if (got_rgb !== 12'h000) begin n_fail++; $display("FAIL wc_before_swap: got %03h want 000", got_rgb); end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL wc_swap_bank: got %0b want 1", active_bank); end
        n = 0;
        while (busy && n < 40) begin n++; tick; end
        n_checks++; if (n != 16) begin n_fail++; $display("FAIL wc_busy_cycles: got %0d want 16", n); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wc_ready_after: got %0b want 1", wr_ready); end
        lookup(4'd3, 1'b0, 4'hF);
        n_checks++; if (got_rgb !== 12'hA97) begin n_fail++; $display("FAIL wc_after_swap: got %03h want a97", got_rgb); end
    endtask

    task automatic test_shadow;
        do_write(4'd3, 12'h123);
        lookup(4'd3, 1'b0, 4'hF);
        n_checks++; if (got_rgb !== 12'hA97) begin n_fail++; $display("FAIL sh_no_commit: got %03h want a97", got_rgb); end
        do_swap;
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL sh_bank: got %0b want 0", active_bank); end
        lookup(4'd3, 1'b0, 4'hF);
        n_checks++; if (got_rgb !== 12'h123) begin n_fail++; $display("FAIL sh_committed: got %03h want 123", got_rgb); end
    endtask

    task automatic test_fade;
        do_write(4'd3, 12'hA97);
        do_swap;
        lookup(4'd3, 1'b0, 4'hF);
        n_checks++; if (got_rgb !== 12'hA97) begin n_fail++; $display("FAIL fade_full: got %03h want a97", got_rgb); end
        lookup(4'd3, 1'b0, 4'h7);
        n_checks++; if (got_rgb !== 12'h543) begin n_fail++; $display("FAIL fade_7: got %03h want 543", got_rgb); end
        lookup(4'd3, 1'b0, 4'h0);
        n_checks++; if (got_rgb !== 12'h000) begin n_fail++; $display("FAIL fade_0: got %03h want 000", got_rgb); end
        lookup(4'd3, 1'b1, 4'hF);
        n_checks++; if (got_rgb !== 12'h000) begin n_fail++; $display("FAIL fade_blank: got %03h want 000", got_rgb); end
    endtask

    task automatic test_back_to_back;
        tick;
        rd_valid = 1'b1; index = 4'd3; blank = 1'b0; fade = 4'hF;
        tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: out_valid=%0b want 0", out_valid); end
        fade = 4'h7;
        tick;
        n_checks++; if ({out_valid, red, green, blue} !== 13'h1A97) begin n_fail++; $display("FAIL b2b_first: got %04h want 1a97", {out_valid, red, green, blue}); end
        fade = 4'h3;
        tick;
        n_checks++; if ({out_valid, red, green, blue} !== 13'h1543) begin n_fail++; $display("FAIL b2b_second: got %04h want 1543", {out_valid, red, green, blue}); end
        rd_valid = 1'b0;
        tick;
        n_checks++; if ({out_valid, red, green, blue} !== 13'h1221) begin n_fail++; $display("FAIL b2b_third: got %04h want 1221", {out_valid, red, green, blue}); end
        tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: out_valid=%0b want 0", out_valid); end
    endtask

    task automatic test_commit_frame_same;
        int n;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n_checks++; if ({busy, active_bank} !== 2'b01) begin n_fail++; $display("FAIL cf_idle_frame: busy,bank=%02b want 01", {busy, active_bank}); end
        commit = 1'b1; frame_start = 1'b1;
        tick;
        commit = 1'b0; frame_start = 1'b0;
        n_checks++; if ({busy, active_bank} !== 2'b11) begin n_fail++; $display("FAIL cf_no_swap: busy,bank=%02b want 11", {busy, active_bank}); end
        wr_valid = 1'b1; wr_index = 4'd2; wr_rgb = 12'h456;
        repeat (3) tick;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL cf_stall: wr_ready=%0b want 0", wr_ready); end
        n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL cf_still_old: bank=%0b want 1", active_bank); end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL cf_swap: bank=%0b want 0", active_bank); end
        n = 0;
        while (!wr_ready && n < 40) begin tick; n++; end
        n_checks++; if (n != 16) begin n_fail++; $display("FAIL cf_ready_delay: got %0d want 16", n); end
        tick;
        wr_valid = 1'b0;
        lookup(4'd2, 1'b0, 4'hF);
        n_checks++; if (got_rgb !== 12'h000) begin n_fail++; $display("FAIL cf_not_visible: got %03h want 000", got_rgb); end
        do_swap;
        lookup(4'd2, 1'b0, 4'hF);
        n_checks++; if (got_rgb !== 12'h456) begin n_fail++; $display("FAIL cf_late_write: got %03h want 456", got_rgb); end
    endtask

    task automatic test_reset_mid_copy;
        do_swap;
        commit = 1'b1;
        tick;
        commit = 1'b0;
        rd_valid = 1'b1; index = 4'd3; blank = 1'b0; fade = 4'hF;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        repeat (7) tick;
        n_checks++; if ({busy, active_bank} !== 2'b11) begin n_fail++; $display("FAIL rc_pre_state: busy,bank=%02b want 11", {busy, active_bank}); end
        n_checks++; if ({out_valid, red, green, blue} !== 13'h1A97) begin n_fail++; $display("FAIL rc_pre_out: got %04h want 1a97", {out_valid, red, green, blue}); end
        #2;
        reset_n = 1'b0;
        rd_valid = 1'b0;
        #1;
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL rc_bank: got %0b want 0", active_bank); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rc_busy: got %0b want 0", busy); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rc_ready: got %0b want 1", wr_ready); end
        n_checks++; if ({out_valid, red, green, blue} !== 13'h0000) begin n_fail++; $display("FAIL rc_out: got %04h want 0000", {out_valid, red, green, blue}); end
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        lookup(4'd2, 1'b0, 4'hF);
        n_checks++; if ({got_vld, got_rgb} !== 13'h1000) begin n_fail++; $display("FAIL rc_lookup2: got %04h want 1000", {got_vld, got_rgb}); end
        lookup(4'd3, 1'b0, 4'hF);
        n_checks++; if ({got_vld, got_rgb} !== 13'h1000) begin n_fail++; $display("FAIL rc_lookup3: got %04h want 1000", {got_vld, got_rgb}); end
    endtask

    initial begin
        test_reset;
        test_write_commit;
        test_shadow;
        test_fade;
        test_back_to_back;
        test_commit_frame_same;
        test_reset_mid_copy;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
